// File: rtl/demux1x2_8bits_sync_if.sv
// rtl/demux1x2_8bits_sync_if.sv - serial lane in, paired half-rate lanes out
interface demux1x2_8bits_sync_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] data_000;
    logic             valid_000;
    logic [WIDTH-1:0] data_00;
    logic             valid_00;
    logic [WIDTH-1:0] data_11;
    logic             valid_11;
    logic             pair_stb;
    logic [CNT_W-1:0] pair_cnt;

    modport master (
        output data_000, valid_000,
        input  data_00, valid_00, data_11, valid_11, pair_stb, pair_cnt
    );

    modport slave (
        input  data_000, valid_000,
        output data_00, valid_00, data_11, valid_11, pair_stb, pair_cnt
    );
endinterface

// File: rtl/demux1x2_8bits_sync.sv
// rtl/demux1x2_8bits_sync.sv - 1-to-2 byte lane splitter on an internal half-rate phase
module demux1x2_8bits_sync #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    demux1x2_8bits_sync_if.slave  bus
);
    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    phase_e           phase_q,      phase_d;
    logic [WIDTH-1:0] hold_data_q,  hold_data_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] data_00_q,    data_00_d;
    logic             valid_00_q,   valid_00_d;
    logic [WIDTH-1:0] data_11_q,    data_11_d;
    logic             valid_11_q,   valid_11_d;
    logic             pair_stb_q,   pair_stb_d;
    logic [CNT_W-1:0] pair_cnt_q,   pair_cnt_d;

    always_comb begin
        phase_d      = phase_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        data_00_d    = data_00_q;
        valid_00_d   = valid_00_q;
        data_11_d    = data_11_q;
        valid_11_d   = valid_11_q;
        pair_stb_d   = 1'b0;
        pair_cnt_d   = pair_cnt_q;

        case (phase_q)
            PH_EVEN: begin
                phase_d      = PH_ODD;
                hold_data_d  = bus.data_000;
                hold_valid_d = bus.valid_000;
            end
            PH_ODD: begin
                // Both lanes publish together so a pair is always coherent on the outputs.
                phase_d    = PH_EVEN;
                data_00_d  = hold_data_q;
                valid_00_d = hold_valid_q;
                data_11_d  = bus.data_000;
                valid_11_d = bus.valid_000;
                pair_stb_d = 1'b1;
                if (hold_valid_q && bus.valid_000) begin
                    pair_cnt_d = pair_cnt_q + 1'b1;
                end
            end
            default: phase_d = PH_EVEN;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            phase_q      <= PH_EVEN;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            data_00_q    <= '0;
            valid_00_q   <= 1'b0;
            data_11_q    <= '0;
            valid_11_q   <= 1'b0;
            pair_stb_q   <= 1'b0;
            pair_cnt_q   <= '0;
        end else begin
            phase_q      <= phase_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            data_00_q    <= data_00_d;
            valid_00_q   <= valid_00_d;
            data_11_q    <= data_11_d;
            valid_11_q   <= valid_11_d;
            pair_stb_q   <= pair_stb_d;
            pair_cnt_q   <= pair_cnt_d;
        end
    end

    assign bus.data_00  = data_00_q;
    assign bus.valid_00 = valid_00_q;
    assign bus.data_11  = data_11_q;
    assign bus.valid_11 = valid_11_q;
    assign bus.pair_stb = pair_stb_q;
    assign bus.pair_cnt = pair_cnt_q;
endmodule

// File: tb/tb_demux1x2_8bits_sync.sv
// tb/tb_demux1x2_8bits_sync.sv - randomized bench for the 1-to-2 lane splitter
module tb_demux1x2_8bits_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    demux1x2_8bits_sync_if #(.WIDTH(8), .CNT_W(8)) bus ();

    demux1x2_8bits_sync #(.WIDTH(8), .CNT_W(8)) dut (
        .clk_4f (clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the stream of words accepted since the last reset; every
    // second word closes a pair whose two words become the visible outputs.
    logic [8:0] words[$];
    logic [7:0] exp_d00, exp_d11;
    logic       exp_v00, exp_v11, exp_stb;
    int         exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic [7:0] d, input logic v);
        if (!rst_n) begin
            words.delete();
            exp_d00 = 8'h00; exp_v00 = 1'b0;
            exp_d11 = 8'h00; exp_v11 = 1'b0;
            exp_stb = 1'b0;  exp_cnt = 0;
        end else begin
            words.push_back({d, v});
            exp_stb = 1'b0;
            if (words.size() % 2 == 0) begin
                exp_d00 = words[words.size()-2][8:1];
                exp_v00 = words[words.size()-2][0];
                exp_d11 = words[words.size()-1][8:1];
                exp_v11 = words[words.size()-1][0];
                exp_stb = 1'b1;
                if (exp_v00 && exp_v11) exp_cnt = (exp_cnt + 1) % 256;
            end
        end
    endtask

    task automatic step(input logic [7:0] d, input logic v);
        bus.data_000  = d;
        bus.valid_000 = v;
        @(posedge clk);
        model_edge(d, v);
        @(negedge clk);
        check("data_00",  {24'd0, bus.data_00},  {24'd0, exp_d00});
        check("valid_00", {31'd0, bus.valid_00}, {31'd0, exp_v00});
        check("data_11",  {24'd0, bus.data_11},  {24'd0, exp_d11});
        check("valid_11", {31'd0, bus.valid_11}, {31'd0, exp_v11});
        check("pair_stb", {31'd0, bus.pair_stb}, {31'd0, exp_stb});
        check("pair_cnt", {24'd0, bus.pair_cnt}, exp_cnt[31:0]);
    endtask

    initial begin
        int cnt_before;
        int stb_seen;
        logic [7:0] a, b;
        logic       va, vb;

        bus.data_000  = 8'h00;
        bus.valid_000 = 1'b0;

        // Reset with random traffic: everything stays cleared.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(8'($urandom), 1'($urandom));
        check("rst_data_00", {24'd0, bus.data_00}, 32'h0);
        check("rst_stb", {31'd0, bus.pair_stb}, 32'h0);

        // Directed pair, then hold on the following cycle.
        rst_n = 1'b1;
        step(8'hA5, 1'b1);
        check("t2_no_stb_even", {31'd0, bus.pair_stb}, 32'h0);
        step(8'h3C, 1'b1);
        check("t2_d00", {24'd0, bus.data_00}, 32'hA5);
        check("t2_d11", {24'd0, bus.data_11}, 32'h3C);
        check("t2_cnt", {24'd0, bus.pair_cnt}, 32'h1);
        step(8'h11, 1'b1);
        check("t2_hold_d00", {24'd0, bus.data_00}, 32'hA5);
        check("t2_hold_stb", {31'd0, bus.pair_stb}, 32'h0);

        // Single valid in a pair: outputs update, counter does not.
        step(8'h22, 1'b0);
        check("t3_v00", {31'd0, bus.valid_00}, 32'h1);
        check("t3_v11", {31'd0, bus.valid_11}, 32'h0);
        check("t3_d11", {24'd0, bus.data_11}, 32'h22);
        check("t3_cnt", {24'd0, bus.pair_cnt}, 32'h1);

        // Reset between the two halves of a pair drops the held word.
        step(8'h77, 1'b1);
        rst_n = 1'b0;
        step(8'h99, 1'b1);
        rst_n = 1'b1;
        step(8'h44, 1'b1);
        step(8'h55, 1'b1);
        check("t4_d00", {24'd0, bus.data_00}, 32'h44);
        check("t4_d11", {24'd0, bus.data_11}, 32'h55);
        check("t4_cnt", {24'd0, bus.pair_cnt}, 32'h1);

        // Counter wrap after 256 valid pairs, strobe on every second edge.
        cnt_before = exp_cnt;
        stb_seen = 0;
        for (int i = 0; i < 256; i++) begin
            step(8'($urandom), 1'b1);
            step(8'($urandom), 1'b1);
            if (bus.pair_stb) stb_seen++;
        end
        check("t5_wrap", {24'd0, bus.pair_cnt}, cnt_before[31:0]);
        check("t5_stb_count", stb_seen, 32'd256);

        // Loopback through a behavioural 2-to-1 serializer: lane 0 then lane 1.
        for (int i = 0; i < 10000; i++) begin
            a = 8'($urandom); va = 1'($urandom);
            b = 8'($urandom); vb = 1'($urandom);
            step(a, va);
            step(b, vb);
            if (i % 1000 == 0) begin
                check("t6_lane0", {23'd0, bus.data_00, bus.valid_00}, {23'd0, a, va});
                check("t6_lane1", {23'd0, bus.data_11, bus.valid_11}, {23'd0, b, vb});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
